// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with XOR checksum and core hold
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH+1)'(1);

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_byte_idx;
    logic [ADDR_WIDTH:0]     r_words_left;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_xor;
    logic [23:0]             r_word;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_imem_addr;
    logic [31:0]             r_imem_wdata;

    logic w_ready;
    logic w_busy;
    logic w_done;
    logic w_error;
    logic w_hold;
    logic w_start_ok;
    logic w_accept;
    logic w_load_byte;
    logic w_word_end;
    logic w_last;

    // start is only honoured while no load is in flight
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_accept    = in_valid && w_ready;
    assign w_load_byte = w_accept && (r_state == S_LOAD);
    assign w_word_end  = w_load_byte && (r_byte_idx == 2'd3);
    assign w_last      = w_word_end && (r_words_left == ONE_WORD);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_error = 1'b0;
        w_hold  = 1'b1;
        unique case (r_state)
            S_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (w_last) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (in_valid) begin
                    w_next = (in_data == r_xor) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                w_done  = (r_state == S_DONE);
                w_error = (r_state == S_ERROR);
                w_hold  = (r_state != S_DONE);
                if (start) begin
                    if (num_words == '0) begin
                        w_next = S_CHECK;
                    end else if (num_words > MAX_WORDS) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
        endcase
    end

    // byte assembly, running checksum and registered memory write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_idx   <= '0;
            r_words_left <= '0;
            r_addr       <= '0;
            r_xor        <= '0;
            r_word       <= '0;
            r_we         <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_we <= w_word_end;
            if (w_start_ok) begin
                r_byte_idx   <= '0;
                r_words_left <= num_words;
                r_addr       <= '0;
                r_xor        <= '0;
            end else if (w_load_byte) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_xor      <= r_xor ^ in_data;
                unique case (r_byte_idx)
                    2'd0: r_word[7:0]   <= in_data;
                    2'd1: r_word[15:8]  <= in_data;
                    2'd2: r_word[23:16] <= in_data;
                    default: begin
                        r_imem_wdata <= {in_data, r_word};
                        r_imem_addr  <= r_addr;
                        r_addr       <= r_addr + ADDR_WIDTH'(1);
                        r_words_left <= r_words_left - ONE_WORD;
                    end
                endcase
            end
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_hold   = w_hold;
    assign busy       = w_busy;
    assign done       = w_done;
    assign error      = w_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int AW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   num_words;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    int checks;
    int failures;
    int writes_seen;
    logic [AW+31:0] sb_q[$];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // write monitor: every imem_we cycle must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            writes_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                logic [AW+31:0] e;
                e = sb_q.pop_front();
                check("we_addr", imem_addr, e[AW+31:32]);
                check("we_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start     = 1'b1;
        num_words = (AW+1)'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // mode 0: fixed two-word program, mode 1: random words
    task automatic run_load(input int n, input int mode, input bit bad, input int maxgap);
        logic [7:0]  x;
        logic [31:0] w;
        int          wr0;
        wr0 = writes_seen;
        x = 8'h00;
        pulse_start(n);
        for (int i = 0; i < n; i++) begin
            if (mode == 0) w = (i == 0) ? 32'h0000_0013 : 32'h0010_0093;
            else           w = $urandom;
            sb_q.push_back({AW'(i % DEPTH), w});
            for (int k = 0; k < 4; k++) begin
                x = x ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
            end
        end
        send_byte(bad ? (x ^ 8'h01) : x, 0);
        idle_bus();
        check("sb_drained", sb_q.size(), 0);
        check("write_count", writes_seen - wr0, n);
        check("done", done, !bad);
        check("error", error, bad);
        check("cpu_hold", cpu_hold, bad);
        check("busy_end", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int ready_seen;
        int wr0;
        checks      = 0;
        failures    = 0;
        writes_seen = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        num_words   = '0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // spec example stream, good then bad checksum, then reload with gaps
        run_load(2, 0, 1'b0, 0);
        run_load(2, 0, 1'b1, 0);
        run_load(2, 0, 1'b0, 3);
        run_load(3, 1, 1'b0, 3);

        // zero words: checksum only
        run_load(0, 0, 1'b0, 0);

        // oversize request goes straight to error without accepting bytes
        wr0 = writes_seen;
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        start     = 1'b1;
        num_words = (AW+1)'(DEPTH + 1);
        ready_seen = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready) ready_seen++;
            if (i == 0) check("oversize_error", error, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("oversize_ready", ready_seen, 0);
        check("oversize_hold", cpu_hold, 1);
        check("oversize_writes", writes_seen - wr0, 0);

        // full memory
        run_load(DEPTH, 1, 1'b0, 0);

        // reset in the middle of the second word
        pulse_start(2);
        sb_q.push_back({AW'(0), 32'hA1B2C3D4});
        send_byte(8'hD4, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hA1, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", in_ready, 0);
        check("midrst_we", imem_we, 0);
        check("midrst_addr", imem_addr, 0);
        check("midrst_hold", cpu_hold, 1);
        check("midrst_sb", sb_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr0 = writes_seen;
        repeat (5) @(negedge clk);
        check("postrst_writes", writes_seen - wr0, 0);

        // start during a load is ignored
        pulse_start(1);
        sb_q.push_back({AW'(0), 32'h0040_0113});
        send_byte(8'h13, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        start     = 1'b1;
        num_words = '0;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_busy", busy, 1);
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13 ^ 8'h01 ^ 8'h40, 0);
        idle_bus();
        check("ignored_sb", sb_q.size(), 0);
        check("ignored_done", done, 1);
        check("ignored_hold", cpu_hold, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
